// File: rtl/pc16_fetch.sv
// pc16_fetch: 16-bit program counter with a valid/ready fetch-address port.
// Issues the current PC to instruction memory, advances it on each accepted
// request, accepts branch redirects, honours pipeline stalls, and flags a
// one-cycle wrap pulse when the PC rolls over from all-ones to zero.
module pc16_fetch #(
    parameter int unsigned           WIDTH      = 16,
    parameter logic [WIDTH-1:0]      RESET_ADDR = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_addr,
    input  logic             stall,
    output logic [WIDTH-1:0] addr_o,
    output logic             addr_valid,
    input  logic             addr_ready,
    output logic             wrap
);

    // BOOT exists so the first valid request appears one edge after reset
    // release rather than combinationally with it.
    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        ISSUE = 2'b01,
        STALL = 2'b10
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;
    logic             wrap_next;
    logic             transfer;

    // A request is consumed only on an edge where both sides agree.
    assign transfer = addr_valid & addr_ready;

    // State register; asynchronous reset returns to BOOT.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: stall selects STALL from any state, otherwise ISSUE.
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = stall ? STALL : ISSUE;
            ISSUE:   state_next = stall ? STALL : ISSUE;
            STALL:   state_next = stall ? STALL : ISSUE;
            default: state_next = BOOT;
        endcase
    end

    // PC next value: redirect beats increment; nothing moves while in BOOT.
    // A redirect coinciding with a transfer still consumes that transfer but
    // suppresses the increment, so the wrap pulse only ever follows a real
    // increment out of all-ones.
    always_comb begin
        pc_next   = pc;
        wrap_next = 1'b0;
        if (state != BOOT) begin
            if (load_en) begin
                pc_next = load_addr;
            end else if (transfer) begin
                pc_next   = pc + WIDTH'(1);
                wrap_next = &pc;
            end
        end
    end

    // PC and wrap registers; reset discards any pending request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc   <= RESET_ADDR;
            wrap <= 1'b0;
        end else begin
            pc   <= pc_next;
            wrap <= wrap_next;
        end
    end

    // Outputs come straight from registers, so memory sees glitch-free values.
    assign addr_o     = pc;
    assign addr_valid = (state == ISSUE);

endmodule

// File: tb/tb_pc16_fetch.sv
// tb_pc16_fetch: directed test of pc16_fetch against a behavioural model,
// plus literal expectations at key points of each scenario.
module tb_pc16_fetch;

    logic        clk;
    logic        rst_n;
    logic        load_en;
    logic [15:0] load_addr;
    logic        stall;
    logic [15:0] addr_o;
    logic        addr_valid;
    logic        addr_ready;
    logic        wrap;

    int n_checks = 0;
    int n_fail   = 0;

    pc16_fetch #(.WIDTH(16), .RESET_ADDR(16'h0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .stall      (stall),
        .addr_o     (addr_o),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: a PC number, a "requesting" flag and a "has left
    // reset" flag, updated from the rules of the handshake.
    logic [15:0] m_pc;
    logic        m_valid;
    logic        m_wrap;
    logic        m_started;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc      <= 16'h0000;
            m_valid   <= 1'b0;
            m_wrap    <= 1'b0;
            m_started <= 1'b0;
        end else begin
            m_started <= 1'b1;
            m_valid   <= !stall;
            if (m_started && load_en) begin
                m_pc   <= load_addr;
                m_wrap <= 1'b0;
            end else if (m_started && m_valid && addr_ready) begin
                m_pc   <= 16'((32'(m_pc) + 1) % 65536);
                m_wrap <= (m_pc == 16'hFFFF);
            end else begin
                m_wrap <= 1'b0;
            end
        end
    end

    // Compare DUT to model every cycle, away from the active edge.
    always @(negedge clk) begin
        check("model_addr",  {16'h0, addr_o}, {16'h0, m_pc});
        check("model_valid", {31'h0, addr_valid}, {31'h0, m_valid});
        check("model_wrap",  {31'h0, wrap}, {31'h0, m_wrap});
    end

    // Watch for the dropped address 0x0020 ever being accepted.
    logic watch_20;
    int   bad_accepts;
    always @(posedge clk) begin
        if (watch_20 && addr_valid && addr_ready && addr_o == 16'h0020)
            bad_accepts++;
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        load_en     = 1'b0;
        load_addr   = 16'h0000;
        stall       = 1'b0;
        addr_ready  = 1'b1;
        watch_20    = 1'b0;
        bad_accepts = 0;

        // Scenario 1: reset state, then sequential issue.
        repeat (3) step();
        check("rst_addr",  {16'h0, addr_o}, 32'h0000);
        check("rst_valid", {31'h0, addr_valid}, 32'h0);
        check("rst_wrap",  {31'h0, wrap}, 32'h0);
        rst_n = 1'b1;
        step();
        check("boot_addr",  {16'h0, addr_o}, 32'h0000);
        check("boot_valid", {31'h0, addr_valid}, 32'h1);
        step();
        check("seq_1", {16'h0, addr_o}, 32'h0001);
        step();
        check("seq_2", {16'h0, addr_o}, 32'h0002);
        step();
        check("seq_3", {16'h0, addr_o}, 32'h0003);

        // Scenario 2: hold ready low at 0x0010.
        addr_ready = 1'b0;
        load_en    = 1'b1;
        load_addr  = 16'h0010;
        step();
        load_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_addr",  {16'h0, addr_o}, 32'h0010);
            check("hold_valid", {31'h0, addr_valid}, 32'h1);
        end
        addr_ready = 1'b1;
        step();
        check("hold_release", {16'h0, addr_o}, 32'h0011);
        addr_ready = 1'b0;

        // Scenario 3: redirect replaces a pending request.
        load_en   = 1'b1;
        load_addr = 16'h0020;
        step();
        check("pend_addr", {16'h0, addr_o}, 32'h0020);
        load_addr = 16'h1234;
        watch_20  = 1'b1;
        step();
        load_en = 1'b0;
        check("redirect_addr", {16'h0, addr_o}, 32'h1234);
        addr_ready = 1'b1;
        repeat (3) step();
        check("redirect_seq", {16'h0, addr_o}, 32'h1237);
        addr_ready = 1'b0;
        watch_20   = 1'b0;
        check("no_accept_20", 32'(bad_accepts), 32'h0);

        // Scenario 4: wrap on increment, never on load.
        load_en   = 1'b1;
        load_addr = 16'hFFFF;
        step();
        load_en = 1'b0;
        check("ffff_addr", {16'h0, addr_o}, 32'hFFFF);
        check("ffff_wrap", {31'h0, wrap}, 32'h0);
        addr_ready = 1'b1;
        step();
        addr_ready = 1'b0;
        check("wrap_addr",  {16'h0, addr_o}, 32'h0000);
        check("wrap_pulse", {31'h0, wrap}, 32'h1);
        step();
        check("wrap_clear", {31'h0, wrap}, 32'h0);
        load_en   = 1'b1;
        load_addr = 16'hFFFF;
        step();
        load_addr  = 16'h0000;
        addr_ready = 1'b1;
        step();
        load_en    = 1'b0;
        addr_ready = 1'b0;
        check("load0_addr", {16'h0, addr_o}, 32'h0000);
        check("load0_wrap", {31'h0, wrap}, 32'h0);

        // Scenario 5: stall during transfer, redirect while stalled.
        load_en   = 1'b1;
        load_addr = 16'h0040;
        step();
        load_en    = 1'b0;
        addr_ready = 1'b1;
        stall      = 1'b1;
        step();
        check("stall_addr",  {16'h0, addr_o}, 32'h0041);
        check("stall_valid", {31'h0, addr_valid}, 32'h0);
        load_en   = 1'b1;
        load_addr = 16'h0100;
        step();
        load_en = 1'b0;
        check("stall_load",  {16'h0, addr_o}, 32'h0100);
        check("stall_valid2", {31'h0, addr_valid}, 32'h0);
        step();
        check("stall_hold", {16'h0, addr_o}, 32'h0100);
        stall = 1'b0;
        step();
        addr_ready = 1'b0;
        check("unstall_addr",  {16'h0, addr_o}, 32'h0100);
        check("unstall_valid", {31'h0, addr_valid}, 32'h1);

        // Scenario 6: asynchronous reset mid-stream.
        load_en   = 1'b1;
        load_addr = 16'h0055;
        step();
        load_en = 1'b0;
        check("pre_rst_addr", {16'h0, addr_o}, 32'h0055);
        #2 rst_n = 1'b0;
        #1;
        check("async_addr",  {16'h0, addr_o}, 32'h0000);
        check("async_valid", {31'h0, addr_valid}, 32'h0);
        step();
        addr_ready = 1'b1;
        rst_n      = 1'b1;
        #1;
        check("rel_valid", {31'h0, addr_valid}, 32'h0);
        step();
        check("resume_addr",  {16'h0, addr_o}, 32'h0000);
        check("resume_valid", {31'h0, addr_valid}, 32'h1);
        step();
        check("resume_seq1", {16'h0, addr_o}, 32'h0001);
        step();
        check("resume_seq2", {16'h0, addr_o}, 32'h0002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
